// File: rtl/vpack_stream_if.sv
// Handshake bundle for vpack_stream: scalar input stream and packed vector output stream.
// The DUT side uses the slave modport; the scalar source / vector sink uses master.
interface vpack_stream_if #(
   parameter int VECTOR_SIZE = 16,
   parameter int INT_SIZE    = 16
);
   localparam int CW = $clog2(VECTOR_SIZE) + 1;

   logic                                  in_valid;
   logic                                  in_ready;
   logic [INT_SIZE-1:0]                   in_data;
   logic                                  in_last;
   logic                                  out_valid;
   logic                                  out_ready;
   logic [VECTOR_SIZE-1:0][INT_SIZE-1:0]  out_data;
   logic [CW-1:0]                         out_count;

   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_count
   );

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_data, out_count
   );
endinterface

// File: rtl/vpack_stream.sv
// Serial-to-parallel vector assembler: fill bank plus output register, one scalar per cycle.
// Optional early close on in_last is enabled by defining VPACK_LAST_EN.
module vpack_stream #(
   parameter int VECTOR_SIZE = 16,
   parameter int INT_SIZE    = 16
) (
   input  logic           clock,
   input  logic           resetn,
   vpack_stream_if.slave  bus
);
   localparam int IW = $clog2(VECTOR_SIZE);
   localparam int CW = IW + 1;

   typedef enum logic [0:0] {
      ST_FILL = 1'b0,
      ST_HOLD = 1'b1
   } state_t;

   state_t                                state_r;
   logic                                  in_ready_r;
   logic [IW-1:0]                         idx_r;
   logic [VECTOR_SIZE-1:0][INT_SIZE-1:0]  bank_r;
   logic                                  out_valid_r;
   logic [VECTOR_SIZE-1:0][INT_SIZE-1:0]  out_data_r;
   logic [CW-1:0]                         out_count_r;

   logic [VECTOR_SIZE-1:0][INT_SIZE-1:0]  bank_next_s;
   logic                                  accept_s;
   logic                                  take_s;
   logic                                  out_free_s;
   logic                                  last_hit_s;
   logic                                  complete_s;
   logic [CW-1:0]                         count_s;

`ifndef VPACK_LAST_EN
   logic unused_last_s;
   assign unused_last_s = bus.in_last;
`endif

   assign bus.in_ready  = in_ready_r;
   assign bus.out_valid = out_valid_r;
   assign bus.out_data  = out_data_r;
   assign bus.out_count = out_count_r;

   // Handshake decode and the fill bank as it would look after this cycle's accept.
   always_comb begin
      bank_next_s         = bank_r;
      bank_next_s[idx_r]  = bus.in_data;
      accept_s            = bus.in_valid && in_ready_r;
      take_s              = out_valid_r && bus.out_ready;
      out_free_s          = !out_valid_r || bus.out_ready;
`ifdef VPACK_LAST_EN
      last_hit_s          = bus.in_last;
`else
      last_hit_s          = 1'b0;
`endif
      complete_s          = accept_s && ((idx_r == IW'(VECTOR_SIZE - 1)) || last_hit_s);
      count_s             = {1'b0, idx_r} + CW'(1);
   end

   // Fill FSM, fill bank and output register; a take and a new load may share one edge.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_r     <= ST_FILL;
         in_ready_r  <= 1'b0;
         idx_r       <= '0;
         bank_r      <= '0;
         out_valid_r <= 1'b0;
         out_data_r  <= '0;
         out_count_r <= '0;
      end else begin
         case (state_r)
            ST_FILL: begin
               in_ready_r <= 1'b1;
               if (complete_s) begin
                  if (out_free_s) begin
                     out_data_r  <= bank_next_s;
                     out_count_r <= count_s;
                     out_valid_r <= 1'b1;
                     bank_r      <= '0;
                     idx_r       <= '0;
                  end else begin
                     // Keep idx so the held vector's lane count is still known at hand-over.
                     bank_r      <= bank_next_s;
                     state_r     <= ST_HOLD;
                     in_ready_r  <= 1'b0;
                  end
               end else begin
                  if (accept_s) begin
                     bank_r <= bank_next_s;
                     idx_r  <= idx_r + IW'(1);
                  end
                  if (take_s) begin
                     out_valid_r <= 1'b0;
                  end
               end
            end
            ST_HOLD: begin
               if (take_s) begin
                  out_data_r  <= bank_r;
                  out_count_r <= count_s;
                  out_valid_r <= 1'b1;
                  bank_r      <= '0;
                  idx_r       <= '0;
                  state_r     <= ST_FILL;
                  in_ready_r  <= 1'b1;
               end
            end
            default: begin
               state_r    <= ST_FILL;
               in_ready_r <= 1'b0;
            end
         endcase
      end
   end
endmodule
